adder_shift_counter: RTL and testbench

//  N-bit register with shift and parallel load, plus an N-bit ripple-carry adder.
//  The adder adds the register contents Q to an external Addend and CarryIn.

---
 rtl/adder_shift_counter.sv | 67 ++++++
 tb/tb_adder_shift_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/adder_shift_counter.sv
// N-bit shift/load register with a ripple-carry adder that adds Q to Addend and CarryIn.
// Loading the sum gives counting (Addend=1) or hold (Addend=0, CarryIn=0).
module adder_shift_counter #(
    parameter int N = 64
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Enable,
    input  logic         Load,
    input  logic         Direction,
    input  logic         LeftInput,
    input  logic         RightInput,
    input  logic [N-1:0] Addend,
    input  logic         CarryIn,
    output logic [N-1:0] Q,
    output logic [N-1:0] Sum,
    output logic         CarryOut
);

    // Returns {carry_out, sum} of a single-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;
    logic [N:0]   carry_s;
    logic [N-1:0] sum_s;

    // Ripple-carry chain: bit i takes its carry from bit i-1, bit 0 from CarryIn.
    always_comb begin
        carry_s    = '0;
        sum_s      = '0;
        carry_s[0] = CarryIn;
        for (int i = 0; i < N; i++) begin
            {carry_s[i+1], sum_s[i]} = full_add(q_q[i], Addend[i], carry_s[i]);
        end
    end

    // Next-state selection: hold, load sum, shift left, or shift right.
    always_comb begin
        q_d = q_q;
        if (!Enable) begin
            q_d = q_q;
        end else if (Load) begin
            q_d = sum_s;
        end else if (Direction) begin
            q_d = {q_q[N-2:0], RightInput};
        end else begin
            q_d = {LeftInput, q_q[N-1:1]};
        end
    end

    // State register, cleared asynchronously by Reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q        = q_q;
    assign Sum      = sum_s;
    assign CarryOut = carry_s[N];

endmodule

// File: tb/tb_adder_shift_counter.sv
// Directed testbench for adder_shift_counter with hand-computed expected values.
module tb_adder_shift_counter;

    localparam int N = 64;

    logic         Clock;
    logic         Reset;
    logic         Enable;
    logic         Load;
    logic         Direction;
    logic         LeftInput;
    logic         RightInput;
    logic [N-1:0] Addend;
    logic         CarryIn;
    logic [N-1:0] Q;
    logic [N-1:0] Sum;
    logic         CarryOut;

    int n_checks = 0;
    int n_fail   = 0;

    adder_shift_counter #(.N(N)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Enable     (Enable),
        .Load       (Load),
        .Direction  (Direction),
        .LeftInput  (LeftInput),
        .RightInput (RightInput),
        .Addend     (Addend),
        .CarryIn    (CarryIn),
        .Q          (Q),
        .Sum        (Sum),
        .CarryOut   (CarryOut)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset      = 1'b1;
        Enable     = 1'b0;
        Load       = 1'b0;
        Direction  = 1'b0;
        LeftInput  = 1'b0;
        RightInput = 1'b0;
        Addend     = 64'h0;
        CarryIn    = 1'b0;
        #3;
        check("reset_q", Q, 64'h0);
        check("reset_sum", Sum, 64'h0);
        check("reset_cout", {63'h0, CarryOut}, 64'h0);
        tick();
        Reset = 1'b0;

        // Load 0xDEAD from Q=0
        Enable = 1'b1;
        Load   = 1'b1;
        Addend = 64'hDEAD;
        tick();
        check("load_dead", Q, 64'hDEAD);

        // Async reset mid-cycle
        Load    = 1'b0;
        Enable  = 1'b0;
        Addend  = 64'h5;
        CarryIn = 1'b1;
        #2;
        Reset = 1'b1;
        #1;
        check("async_reset_q", Q, 64'h0);
        check("async_reset_sum", Sum, 64'h6);
        #1;
        Reset = 1'b0;
        #1;
        check("reset_release_q", Q, 64'h0);

        // Count 5 edges from 0
        Enable  = 1'b1;
        Load    = 1'b1;
        Addend  = 64'h1;
        CarryIn = 1'b0;
        tick();
        check("count_1", Q, 64'h1);
        tick();
        tick();
        tick();
        tick();
        check("count_5", Q, 64'h5);
        check("count_sum", Sum, 64'h6);
        check("count_cout", {63'h0, CarryOut}, 64'h0);

        // Reset during counting, then resume from 0
        tick();
        tick();
        check("count_7", Q, 64'h7);
        #2;
        Reset = 1'b1;
        #1;
        check("count_abort", Q, 64'h0);
        #1;
        Reset = 1'b0;
        tick();
        check("count_resume", Q, 64'h1);

        // Wrap: Q = all ones, +1
        Addend = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        check("load_ones", Q, 64'hFFFF_FFFF_FFFF_FFFF);
        Addend = 64'h1;
        #1;
        check("wrap_sum", Sum, 64'h0);
        check("wrap_cout", {63'h0, CarryOut}, 64'h1);
        tick();
        check("wrap_q", Q, 64'h0);

        // Left shift
        Addend = 64'h8000_0000_0000_0001;
        tick();
        check("load_8001", Q, 64'h8000_0000_0000_0001);
        Load       = 1'b0;
        Direction  = 1'b1;
        RightInput = 1'b1;
        tick();
        check("shift_left", Q, 64'h0000_0000_0000_0003);

        // Right shift: reload 0x8000..01 via 3 + 0x7FFF..FE
        Load       = 1'b1;
        RightInput = 1'b0;
        Addend     = 64'h7FFF_FFFF_FFFF_FFFE;
        tick();
        check("reload_8001", Q, 64'h8000_0000_0000_0001);
        Load      = 1'b0;
        Direction = 1'b0;
        LeftInput = 1'b0;
        tick();
        check("shift_right_0", Q, 64'h4000_0000_0000_0000);
        LeftInput = 1'b1;
        tick();
        check("shift_right_1", Q, 64'hA000_0000_0000_0000);
        LeftInput = 1'b0;
        Direction = 1'b1;
        tick();
        check("shift_left_msb_drop", Q, 64'h4000_0000_0000_0000);

        // Combinational adder with carry-in
        Addend  = 64'h4000_0000_0000_0000;
        CarryIn = 1'b1;
        #1;
        check("add_cin_sum", Sum, 64'h8000_0000_0000_0001);
        check("add_cin_cout", {63'h0, CarryOut}, 64'h0);
        Addend  = 64'hC000_0000_0000_0000;
        CarryIn = 1'b0;
        #1;
        check("add_wrap_sum", Sum, 64'h0);
        check("add_wrap_cout", {63'h0, CarryOut}, 64'h1);

        // Enable=0 holds despite Load
        Enable = 1'b0;
        Load   = 1'b1;
        Addend = 64'h7;
        tick();
        check("enable_hold", Q, 64'h4000_0000_0000_0000);

        // Load of Q+0 holds
        Enable = 1'b1;
        Addend = 64'h0;
        tick();
        check("load_hold", Q, 64'h4000_0000_0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
